// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master round-robin arbiter onto a pipelined memory port with watchdog
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;

  // Owner / last-grant encoding: 0 = instruction port, 1 = data port
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  // Abort fires on the TIMEOUT-th cycle spent in ISSUE+WAIT_RD
  localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_owner;
  logic        r_last_grant;
  logic        r_is_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [9:0]  r_wdog;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_i_wait;
  logic        r_d_wait;
  logic        r_bus_err;

  logic w_d_req;
  logic w_grant_valid;
  logic w_grant_d;
  logic w_busy;
  logic w_accept;
  logic w_rd_done;
  logic w_abort;

  // Arbitration and completion decode; a real completion in the timeout cycle wins over the abort
  always_comb begin
    w_d_req       = d_read | d_write;
    w_grant_valid = i_read | w_d_req;
    w_grant_d     = w_d_req & (~i_read | (r_last_grant == OWN_I));
    w_busy        = (r_state == S_ISSUE) || (r_state == S_WAIT_RD);
    w_accept      = (r_state == S_ISSUE) && !m_waitrequest;
    w_rd_done     = (r_state == S_WAIT_RD) && m_readdatavalid;
    w_abort       = w_busy && (r_wdog == WDOG_LAST) && !w_rd_done && !(w_accept && r_is_write);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_grant_valid) w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_abort)       w_next = S_RESP;
        else if (w_accept) w_next = r_is_write ? S_RESP : S_WAIT_RD;
      end
      S_WAIT_RD: if (w_abort || w_rd_done) w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Command latch, watchdog, response registers and sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner      <= OWN_I;
      r_last_grant <= OWN_I;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_wdog       <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_wait     <= 1'b1;
      r_d_wait     <= 1'b1;
      r_bus_err    <= 1'b0;
    end else begin
      r_i_wait <= !((w_next == S_RESP) && (r_owner == OWN_I));
      r_d_wait <= !((w_next == S_RESP) && (r_owner == OWN_D));
      if (w_busy) r_wdog <= r_wdog + 10'd1;
      if ((r_state == S_IDLE) && w_grant_valid) begin
        r_owner      <= w_grant_d;
        r_last_grant <= w_grant_d;
        r_wdog       <= '0;
        if (w_grant_d) begin
          r_addr     <= d_address;
          r_is_write <= d_write & ~d_read;
          r_wdata    <= d_writedata;
          r_be       <= (d_write & ~d_read) ? d_byteenable : 4'hF;
          if (d_read && d_write) r_bus_err <= 1'b1;
        end else begin
          r_addr     <= i_address;
          r_is_write <= 1'b0;
          r_be       <= 4'hF;
        end
      end
      if (w_rd_done) begin
        if (r_owner == OWN_I) r_i_rdata <= m_readdata;
        else                  r_d_rdata <= m_readdata;
      end
      if (w_abort) begin
        r_bus_err <= 1'b1;
        if (r_owner == OWN_I) r_i_rdata <= ERR_DATA;
        else                  r_d_rdata <= ERR_DATA;
      end
    end
  end

  assign m_read        = (r_state == S_ISSUE) && !r_is_write;
  assign m_write       = (r_state == S_ISSUE) && r_is_write;
  assign m_address     = r_addr;
  assign m_writedata   = r_wdata;
  assign m_byteenable  = r_be;
  assign i_waitrequest = r_i_wait;
  assign d_waitrequest = r_d_wait;
  assign i_readdata    = r_i_rdata;
  assign d_readdata    = r_d_rdata;
  assign bus_err       = r_bus_err;

endmodule
